pixel_scheduler: RTL and testbench
==================================

Name: pixel_scheduler

Overview:
- Sequences the pipelined pixel compute core for one video frame and returns its results as an AXI4-Stream video output.
- Issues (x,y) coordinates in raster order into the core and tags each issued pixel with start-of-frame and end-of-line.
- Collects the core's in-order results in an output FIFO and presents them downstream with tuser=SOF and tlast=EOL.
- Uses credit-based issue, so downstream backpressure never overflows the FIFO and the core needs no stall input.

Parameters:
- X_SIZE, 480, pixels per line
- Y_SIZE, 480, lines per frame
- COORD_W, 10, coordinate width; must satisfy 2^COORD_W >= max(X_SIZE, Y_SIZE)
- DATA_W, 32, result/tdata width
- FIFO_DEPTH, 32, output FIFO and tag FIFO depth; power of 2, >= 2

Ports:
- out_stream_aclk  in  1  sole clock
- periph_reset  in  1  asynchronous, active-high reset
- start  in  1  begin frame; sampled in IDLE only
- continuous  in  1  when 1, auto-restart the next frame after DRAIN
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse at end of each frame
- err  out  1  sticky protocol error
- core_valid_in  out  1  issue strobe to core
- core_x  out  COORD_W  issued x coordinate
- core_y  out  COORD_W  issued y coordinate
- core_valid_out  in  1  core result strobe; results arrive in issue order
- core_data  in  DATA_W  core result
- out_stream_tdata  out  DATA_W  pixel data
- out_stream_tvalid  out  1  stream valid
- out_stream_tready  in  1  stream ready
- out_stream_tlast  out  1  last pixel of line
- out_stream_tuser  out  1  first pixel of frame
- out_stream_tkeep  out  DATA_W/8  constant all-ones

Behaviour:
- Reset (asynchronous; all outputs take their reset values immediately on assertion):
  - state=IDLE; x=y=0; in_flight=0; FIFOs empty.
  - busy, frame_done, err, core_valid_in, out_stream_tvalid, out_stream_tlast, out_stream_tuser all 0; core_x=core_y=0.
  - A reset mid-frame discards all in-flight and buffered pixels.
- State machine, IDLE/RUN/DRAIN:
  - IDLE: start=1 at a clock edge -> RUN. start in RUN or DRAIN is ignored.
  - RUN: issues one pixel per cycle while credit_ok, with credit_ok = (in_flight + fifo_count) < FIFO_DEPTH.
  - RUN: the issue of the pixel (X_SIZE-1, Y_SIZE-1) -> DRAIN.
  - DRAIN: when in_flight==0, the FIFO is empty and no handshake is pending -> frame_done=1 for one cycle.
  - DRAIN exit: -> RUN with x=y=0 if continuous=1, else -> IDLE.
- Issue timing:
  - core_valid_in, core_x and core_y are registered.
  - The first issue is visible the cycle after start is sampled.
  - Raster order: x increments and wraps at X_SIZE-1 to 0, then y increments.
  - No wasted cycles while credit is available.
- Tags:
  - Each issue pushes {sof = (x==0 && y==0), eol = (x==X_SIZE-1)} into the tag FIFO.
  - Each core_valid_out pops one tag and writes {core_data, sof, eol} into the output FIFO.
- in_flight:
  - +1 on issue, -1 on core_valid_out, unchanged when both occur in the same cycle.
  - Range 0..FIFO_DEPTH.
- Output stream, AXI4-Stream rules:
  - tvalid = FIFO not empty.
  - Once asserted, tdata, tlast and tuser hold until tready && tvalid.
  - The FIFO pops on handshake; simultaneous push and pop is supported at any occupancy, including full and empty.
  - Write-to-tvalid latency is at most 1 cycle.
- Error handling:
  - err sets on core_valid_out with in_flight==0 (the beat is dropped) or on any write to a full output FIFO (the beat is dropped).
  - err is cleared only by reset.
- Sustained throughput is 1 pixel/cycle when tready is held 1 and the core returns 1 result/cycle.

Test Plan (bench parameters X_SIZE=4, Y_SIZE=3, FIFO_DEPTH=8; core model is a 5-cycle delay line):
1. Single frame: start pulse with tready=1 -> exactly 12 beats with data in issue order; tuser only on beat 0; tlast on beats 3, 7 and 11; frame_done pulses once after beat 11; busy returns to 0; err=0.
2. Backpressure: tready=0 for 100 cycles mid-frame -> issue stalls once in_flight+fifo_count=8; no beat is lost or duplicated; all 12 beats arrive in order after tready returns to 1.
3. Random tready (50% PRBS) with continuous=1 for 3 frames -> 36 beats; tuser on beats 0, 12 and 24; tlast every 4th beat; 3 frame_done pulses.
4. Reset asserted at beat 6 -> tvalid and busy are 0 immediately; after release, a new start produces a full frame starting at x=0, y=0 with tuser=1.
5. core_valid_out pulsed in IDLE -> err=1 and stays 1; no stream beat is produced; a following frame still completes correctly.
6. start pulsed during RUN and during DRAIN -> ignored; exactly 12 beats and one frame_done are produced.

Source files
------------

// File: rtl/pixel_scheduler.sv
// Pixel scheduler: walks one video frame in raster order into a pipelined
// compute core, tags each pixel with SOF/EOL, and returns the core's in-order
// results on an AXI4-Stream video output through a credit-protected FIFO.
module pixel_scheduler #(
  parameter int unsigned X_SIZE     = 480,
  parameter int unsigned Y_SIZE     = 480,
  parameter int unsigned COORD_W    = 10,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 32
) (
  input  logic                  out_stream_aclk,
  input  logic                  periph_reset,
  input  logic                  start,
  input  logic                  continuous,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err,
  output logic                  core_valid_in,
  output logic [COORD_W-1:0]    core_x,
  output logic [COORD_W-1:0]    core_y,
  input  logic                  core_valid_out,
  input  logic [DATA_W-1:0]     core_data,
  output logic [DATA_W-1:0]     out_stream_tdata,
  output logic                  out_stream_tvalid,
  input  logic                  out_stream_tready,
  output logic                  out_stream_tlast,
  output logic                  out_stream_tuser,
  output logic [DATA_W/8-1:0]   out_stream_tkeep
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [COORD_W-1:0] XLast  = COORD_W'(X_SIZE - 1);
  localparam logic [COORD_W-1:0] YLast  = COORD_W'(Y_SIZE - 1);
  localparam logic [CW-1:0]      DepthC = CW'(FIFO_DEPTH);
  localparam logic [CW:0]        DepthW = (CW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  // Control state
  state_e               state_q;
  logic [COORD_W-1:0]   x_q, y_q;
  logic                 core_valid_in_q;
  logic [COORD_W-1:0]   core_x_q, core_y_q;
  logic                 frame_done_q;

  // Bookkeeping
  logic [CW-1:0]        in_flight_q, in_flight_d;
  logic                 err_q, err_d;

  // Tag FIFO: one {sof, eol} entry per pixel inside the core
  logic [1:0]           tag_mem_q [FIFO_DEPTH];
  logic [AW-1:0]        tag_wr_ptr_q, tag_rd_ptr_q;

  // Output FIFO: {data, sof, eol}
  logic [DATA_W+1:0]    of_mem_q [FIFO_DEPTH];
  logic [AW-1:0]        of_wr_ptr_q, of_rd_ptr_q;
  logic [CW-1:0]        of_count_q, of_count_d;

  // Combinational helpers
  logic [CW:0]          occupancy;
  logic                 credit_ok;
  logic                 issue;
  logic                 last_pix;
  logic                 ret_ok;
  logic                 ret_bad;
  logic                 of_full;
  logic                 of_pop;
  logic                 of_push;
  logic                 of_overflow;
  logic                 drain_done;
  logic [1:0]           tag_in;
  logic [1:0]           tag_out;
  logic [DATA_W+1:0]    of_head;

  // Credit, issue and return decisions for the current cycle
  always_comb begin
    // Every pixel issued but not yet popped downstream holds one FIFO slot
    occupancy   = {1'b0, in_flight_q} + {1'b0, of_count_q};
    credit_ok   = occupancy < DepthW;
    issue       = credit_ok && ((state_q == StIdle && start) || state_q == StRun);
    last_pix    = (x_q == XLast) && (y_q == YLast);
    ret_ok      = core_valid_out && (in_flight_q != '0);
    ret_bad     = core_valid_out && (in_flight_q == '0);
    of_full     = (of_count_q == DepthC);
    of_pop      = (of_count_q != '0) && out_stream_tready;
    of_push     = ret_ok && (!of_full || of_pop);
    of_overflow = ret_ok && of_full && !of_pop;
    drain_done  = (state_q == StDrain) && (in_flight_q == '0) && (of_count_q == '0);
    tag_in      = {(x_q == '0) && (y_q == '0), x_q == XLast};
    tag_out     = tag_mem_q[tag_rd_ptr_q];
    of_head     = of_mem_q[of_rd_ptr_q];
  end

  // Next-state for the counters and the sticky error
  always_comb begin
    in_flight_d = in_flight_q;
    if (issue && !ret_ok) begin
      in_flight_d = in_flight_q + CW'(1);
    end else if (!issue && ret_ok) begin
      in_flight_d = in_flight_q - CW'(1);
    end

    of_count_d = of_count_q;
    if (of_push && !of_pop) begin
      of_count_d = of_count_q + CW'(1);
    end else if (!of_push && of_pop) begin
      of_count_d = of_count_q - CW'(1);
    end

    err_d = err_q | ret_bad | of_overflow;
  end

  // Frame FSM with the registered issue port and frame_done pulse
  always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
    if (periph_reset) begin
      state_q         <= StIdle;
      x_q             <= '0;
      y_q             <= '0;
      core_valid_in_q <= 1'b0;
      core_x_q        <= '0;
      core_y_q        <= '0;
      frame_done_q    <= 1'b0;
    end else begin
      frame_done_q    <= 1'b0;
      core_valid_in_q <= issue;

      if (issue) begin
        core_x_q <= x_q;
        core_y_q <= y_q;
        if (x_q == XLast) begin
          x_q <= '0;
          y_q <= (y_q == YLast) ? '0 : y_q + COORD_W'(1);
        end else begin
          x_q <= x_q + COORD_W'(1);
        end
      end

      unique case (state_q)
        StIdle: begin
          // The first pixel goes out on the same edge that samples start
          if (start) begin
            state_q <= (issue && last_pix) ? StDrain : StRun;
          end
        end
        StRun: begin
          if (issue && last_pix) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (drain_done) begin
            frame_done_q <= 1'b1;
            x_q          <= '0;
            y_q          <= '0;
            state_q      <= continuous ? StRun : StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Pointers, counters and the sticky error flag
  always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
    if (periph_reset) begin
      in_flight_q  <= '0;
      err_q        <= 1'b0;
      tag_wr_ptr_q <= '0;
      tag_rd_ptr_q <= '0;
      of_wr_ptr_q  <= '0;
      of_rd_ptr_q  <= '0;
      of_count_q   <= '0;
    end else begin
      in_flight_q <= in_flight_d;
      err_q       <= err_d;
      of_count_q  <= of_count_d;
      if (issue) begin
        tag_wr_ptr_q <= tag_wr_ptr_q + AW'(1);
      end
      // A returned beat consumes its tag even if the output FIFO drops it
      if (ret_ok) begin
        tag_rd_ptr_q <= tag_rd_ptr_q + AW'(1);
      end
      if (of_push) begin
        of_wr_ptr_q <= of_wr_ptr_q + AW'(1);
      end
      if (of_pop) begin
        of_rd_ptr_q <= of_rd_ptr_q + AW'(1);
      end
    end
  end

  // Tag storage; contents need no reset since pointers qualify every read
  always_ff @(posedge out_stream_aclk) begin
    if (issue) begin
      tag_mem_q[tag_wr_ptr_q] <= tag_in;
    end
  end

  // Output FIFO storage
  always_ff @(posedge out_stream_aclk) begin
    if (of_push) begin
      of_mem_q[of_wr_ptr_q] <= {core_data, tag_out};
    end
  end

  // Head entry is stable until popped, so the stream fields hold under backpressure
  assign out_stream_tvalid = (of_count_q != '0);
  assign out_stream_tdata  = out_stream_tvalid ? of_head[DATA_W+1:2] : '0;
  assign out_stream_tuser  = out_stream_tvalid & of_head[1];
  assign out_stream_tlast  = out_stream_tvalid & of_head[0];
  assign out_stream_tkeep  = '1;

  assign busy          = (state_q != StIdle);
  assign frame_done    = frame_done_q;
  assign err           = err_q;
  assign core_valid_in = core_valid_in_q;
  assign core_x        = core_x_q;
  assign core_y        = core_y_q;

endmodule

// File: tb/tb_pixel_scheduler.sv
// Bench for pixel_scheduler: 4x3 frame, 8-deep FIFOs, 5-cycle core delay line.
// Expected beats are queued per started frame; a negedge monitor pops and compares.
module tb_pixel_scheduler;

  localparam int unsigned XS   = 4;
  localparam int unsigned YS   = 3;
  localparam int unsigned CWD  = 10;
  localparam int unsigned DW   = 32;
  localparam int unsigned FD   = 8;
  localparam int unsigned LAT  = 5;
  localparam int unsigned NPIX = XS * YS;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sof;
    logic          eol;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic            continuous = 1'b0;
  logic            tready = 1'b0;
  logic            inject = 1'b0;
  logic            rand_ready = 1'b0;
  logic            busy, frame_done, err, cvi;
  logic [CWD-1:0]  cx, cy;
  logic            core_ret;
  logic [DW-1:0]   cdata;
  logic [DW-1:0]   tdata;
  logic            tvalid, tlast, tuser;
  logic [DW/8-1:0] tkeep;

  int tests = 0;
  int fails = 0;
  int rx_cnt = 0;
  int issued = 0;
  int done_cnt = 0;

  beat_t exp_q[$];
  beat_t mon_e;
  beat_t hold_b;
  logic  hold_pend = 1'b0;

  always #5 clk = ~clk;

  pixel_scheduler #(
    .X_SIZE    (XS),
    .Y_SIZE    (YS),
    .COORD_W   (CWD),
    .DATA_W    (DW),
    .FIFO_DEPTH(FD)
  ) dut (
    .out_stream_aclk  (clk),
    .periph_reset     (rst),
    .start            (start),
    .continuous       (continuous),
    .busy             (busy),
    .frame_done       (frame_done),
    .err              (err),
    .core_valid_in    (cvi),
    .core_x           (cx),
    .core_y           (cy),
    .core_valid_out   (core_ret),
    .core_data        (cdata),
    .out_stream_tdata (tdata),
    .out_stream_tvalid(tvalid),
    .out_stream_tready(tready),
    .out_stream_tlast (tlast),
    .out_stream_tuser (tuser),
    .out_stream_tkeep (tkeep)
  );

  function automatic logic [DW-1:0] pix_val(input int unsigned x, input int unsigned y);
    return (x * 32'h9E37_79B1) ^ (y * 32'h85EB_CA77) ^ 32'h5A5A_0000;
  endfunction

  // Core model: fixed 5-cycle delay line computing pix_val of the issued coordinate
  logic [LAT-1:0] vpipe;
  logic [DW-1:0]  dpipe [LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      vpipe <= '0;
    end else begin
      vpipe    <= {vpipe[LAT-2:0], cvi};
      dpipe[0] <= pix_val(32'(cx), 32'(cy));
      for (int i = 1; i < LAT; i++) dpipe[i] <= dpipe[i-1];
    end
  end
  assign core_ret = vpipe[LAT-1] | inject;
  assign cdata    = dpipe[LAT-1];

  // Random downstream ready
  always @(posedge clk) begin
    if (rand_ready) begin
      #1 tready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (cvi) issued++;
      if (frame_done) begin
        done_cnt++;
        tests++;
        if (rx_cnt == 0 || (rx_cnt % NPIX) != 0) begin
          fails++;
          $display("FAIL frame_done_position: beats received=%0d, required a nonzero multiple of %0d",
                   rx_cnt, NPIX);
        end
      end
      if (hold_pend) begin
        tests++;
        if (!tvalid || {tdata, tuser, tlast} != hold_b) begin
          fails++;
          $display("FAIL axi_hold: got valid=%0b data=%h sof=%0b eol=%0b required valid=1 data=%h sof=%0b eol=%0b",
                   tvalid, tdata, tuser, tlast, hold_b.d, hold_b.sof, hold_b.eol);
        end
      end
      if (tvalid && tready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_beat: got data=%h sof=%0b eol=%0b, required no beat",
                   tdata, tuser, tlast);
        end else begin
          mon_e = exp_q.pop_front();
          if ({tdata, tuser, tlast} != mon_e) begin
            fails++;
            $display("FAIL beat[%0d]: got data=%h sof=%0b eol=%0b required data=%h sof=%0b eol=%0b",
                     rx_cnt, tdata, tuser, tlast, mon_e.d, mon_e.sof, mon_e.eol);
          end
        end
        rx_cnt++;
      end
      hold_pend = tvalid && !tready;
      hold_b    = {tdata, tuser, tlast};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push_frame();
    beat_t b;
    for (int unsigned y = 0; y < YS; y++) begin
      for (int unsigned x = 0; x < XS; x++) begin
        b.d   = pix_val(x, y);
        b.sof = (x == 0) && (y == 0);
        b.eol = (x == XS - 1);
        exp_q.push_back(b);
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(done_cnt), 32'(target));
  endtask

  task automatic wait_rx(input int target, input int budget, input string name);
    int n = 0;
    while (rx_cnt < target && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(rx_cnt >= target), 32'd1);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    exp_q.delete();
    hold_pend = 1'b0;
    repeat (3) tick();
    rx_cnt   = 0;
    issued   = 0;
    done_cnt = 0;
    rst = 1'b0;
    tick();
  endtask

  initial begin
    int rx0;
    int is0;
    int dn0;
    int n;

    // Reset values
    #1 rst = 1'b1;
    #2;
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_done", 32'(frame_done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_core_valid_in", 32'(cvi), 0);
    check("rst_tvalid", 32'(tvalid), 0);
    check("rst_tlast_tuser", 32'({tlast, tuser}), 0);
    check("rst_core_xy", 32'({cx, cy}), 0);
    check("rst_tkeep", 32'(tkeep), 32'hF);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // 1: single frame
    tready = 1'b1;
    rx0 = rx_cnt;
    dn0 = done_cnt;
    push_frame();
    pulse_start();
    check("t1_first_issue", 32'({cvi, cx, cy}), 32'({1'b1, 10'd0, 10'd0}));
    wait_done(dn0 + 1, 300, "t1_frame_done");
    repeat (10) tick();
    check("t1_beats", 32'(rx_cnt - rx0), NPIX);
    check("t1_single_done", 32'(done_cnt - dn0), 1);
    check("t1_busy", 32'(busy), 0);
    check("t1_err", 32'(err), 0);
    check("t1_queue_empty", 32'(exp_q.size()), 0);

    // 2: backpressure mid-frame
    rx0 = rx_cnt;
    is0 = issued;
    dn0 = done_cnt;
    push_frame();
    pulse_start();
    wait_rx(rx0 + 2, 100, "t2_first_beats");
    tready = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      check("t2_credit_bound", 32'((issued - is0) - (rx_cnt - rx0) <= FD), 1);
    end
    check("t2_stall_outstanding", 32'((issued - is0) - (rx_cnt - rx0)), FD);
    tready = 1'b1;
    wait_done(dn0 + 1, 300, "t2_frame_done");
    repeat (10) tick();
    check("t2_beats", 32'(rx_cnt - rx0), NPIX);
    check("t2_busy", 32'(busy), 0);
    check("t2_err", 32'(err), 0);

    // 3: random ready, continuous, 3 frames
    rx0 = rx_cnt;
    dn0 = done_cnt;
    push_frame();
    push_frame();
    push_frame();
    continuous = 1'b1;
    rand_ready = 1'b1;
    pulse_start();
    wait_done(dn0 + 2, 3000, "t3_two_frames");
    continuous = 1'b0;
    wait_done(dn0 + 3, 3000, "t3_three_frames");
    rand_ready = 1'b0;
    tick();
    tready = 1'b1;
    repeat (20) tick();
    check("t3_beats", 32'(rx_cnt - rx0), 3 * NPIX);
    check("t3_done_pulses", 32'(done_cnt - dn0), 3);
    check("t3_busy", 32'(busy), 0);
    check("t3_queue_empty", 32'(exp_q.size()), 0);

    // 4: reset at beat 6
    rx0 = rx_cnt;
    push_frame();
    pulse_start();
    wait_rx(rx0 + 6, 200, "t4_reach_beat6");
    rst = 1'b1;
    #1;
    check("t4_tvalid_async", 32'(tvalid), 0);
    check("t4_busy_async", 32'(busy), 0);
    check("t4_cvi_async", 32'(cvi), 0);
    apply_reset();
    push_frame();
    pulse_start();
    wait_done(1, 300, "t4_frame_done");
    repeat (10) tick();
    check("t4_beats", 32'(rx_cnt), NPIX);
    check("t4_err", 32'(err), 0);

    // 6: start ignored in RUN and DRAIN
    rx0 = rx_cnt;
    is0 = issued;
    dn0 = done_cnt;
    push_frame();
    pulse_start();
    tick();
    pulse_start();
    n = 0;
    while ((issued - is0) < int'(NPIX) && n < 200) begin
      tick();
      n++;
    end
    check("t6_in_drain", 32'(busy && (issued - is0) == int'(NPIX)), 1);
    pulse_start();
    wait_done(dn0 + 1, 300, "t6_frame_done");
    repeat (40) tick();
    check("t6_beats", 32'(rx_cnt - rx0), NPIX);
    check("t6_single_done", 32'(done_cnt - dn0), 1);
    check("t6_busy", 32'(busy), 0);

    // 5: stray core result in IDLE
    rx0 = rx_cnt;
    dn0 = done_cnt;
    inject = 1'b1;
    tick();
    inject = 1'b0;
    tick();
    check("t5_err_set", 32'(err), 1);
    repeat (20) tick();
    check("t5_err_sticky", 32'(err), 1);
    check("t5_no_beat", 32'(rx_cnt - rx0), 0);
    push_frame();
    pulse_start();
    wait_done(dn0 + 1, 300, "t5_frame_done");
    repeat (10) tick();
    check("t5_beats", 32'(rx_cnt - rx0), NPIX);
    check("t5_err_still", 32'(err), 1);
    check("t5_queue_empty", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
